// File: rtl/uart_rx_lanes_if.sv
// uart_rx_lanes_if: lane-side inputs and frame-side outputs of the
// multi-lane UART receiver.
//   clkdiv      bit period in clock cycles (latched at each start edge)
//   uart_in     serial lines, idle high
//   data        received payload, updated only with valid
//   frame_type  00 data, 01 comma1, 10 comma2
//   valid, framing_err, type_err, skew_err   one-cycle pulses
//   busy        receiver is not idle
// master: the receiver. slave: the consumer that drives lanes/clkdiv.
interface uart_rx_lanes_if #(
  parameter int LANES    = 5,
  parameter int SYM_W    = 10,
  parameter int CLKDIV_W = 10
);
  logic [CLKDIV_W-1:0]    clkdiv;
  logic [LANES-1:0]       uart_in;
  logic [LANES*SYM_W-1:0] data;
  logic [1:0]             frame_type;
  logic                   valid;
  logic                   framing_err;
  logic                   type_err;
  logic                   skew_err;
  logic                   busy;

  modport master (
    input  clkdiv, uart_in,
    output data, frame_type, valid, framing_err, type_err, skew_err, busy
  );

  modport slave (
    output clkdiv, uart_in,
    input  data, frame_type, valid, framing_err, type_err, skew_err, busy
  );
endinterface

// File: rtl/uart_rx_lanes.sv
// uart_rx_lanes: multi-lane UART receiver with in-band frame type.
// Per lane: start(0), 2 type bits MSB first, payload MSB first, stop(1).
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset
//   bus   uart_rx_lanes_if.master (clkdiv, uart_in in; data, frame_type,
//         valid, framing_err, type_err, skew_err, busy out)
// Build option: define UART_RX_MAJORITY_VOTE_EN to decide every bit by a
// 2-of-3 vote over the samples at m-1, m, m+1 (decision one cycle later).
//
// state     | meaning
// IDLE      | waiting for any lane to go low
// START     | waiting for mid start bit, checking lane alignment
// TYPE      | collecting the 2 type bits
// PAYLOAD   | shifting payload bits into the per-lane registers
// STOP      | checking the stop bit
// WAIT_IDLE | after an error, waiting for all lanes high
module uart_rx_lanes #(
  parameter int LANES    = 5,
  parameter int SYM_W    = 10,
  parameter int C1_BITS  = 2,
  parameter int C2_BITS  = 4,
  parameter int CLKDIV_W = 10
) (
  input logic CLK,
  input logic RST,
  uart_rx_lanes_if.master bus
);
  localparam int BC_W = $clog2(SYM_W + 1);
  localparam int DW   = LANES * SYM_W;

  typedef enum logic [2:0] {IDLE, START, TYPE, PAYLOAD, STOP, WAIT_IDLE} state_t;

  state_t state, state_nx;

  logic [LANES-1:0]            sync1, sync2, bit_now;
  logic [CLKDIV_W-1:0]         clkdiv_eff, start_load;
  logic [CLKDIV_W-1:0]         period, period_nx, cnt, cnt_nx, cnt_step;
  logic [BC_W-1:0]             bit_cnt, bit_cnt_nx;
  logic [LANES-1:0]            ty_hi, ty_hi_nx;
  logic [1:0]                  ftype, ftype_nx;
  logic [LANES-1:0][SYM_W-1:0] shreg, shreg_nx;
  logic                        tick, ty_bad;
  logic                        valid_nx, ferr_nx, terr_nx, serr_nx;
  logic [DW-1:0]               data_pk, data_q;
  logic [1:0]                  frame_type_q;
  logic                        valid_q, ferr_q, terr_q, serr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.uart_in;
      sync2 <= sync1;
    end
  end

  assign clkdiv_eff = (bus.clkdiv < CLKDIV_W'(4)) ? CLKDIV_W'(4) : bus.clkdiv;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [LANES-1:0] hist1, hist2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist1 <= '1;
      hist2 <= '1;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  // current cycle is m+1; hist1 holds m, hist2 holds m-1
  assign bit_now    = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
  assign start_load = clkdiv_eff >> 1;
`else
  assign bit_now    = sync2;
  // the detect cycle itself counts as phase 0
  assign start_load = (clkdiv_eff >> 1) - 1'b1;
`endif

  assign tick     = (cnt == '0);
  assign cnt_step = tick ? period - 1'b1 : cnt - 1'b1;

  function automatic logic [BC_W-1:0] last_idx(input logic [1:0] t);
    case (t)
      2'b01:   last_idx = BC_W'(C1_BITS - 1);
      2'b10:   last_idx = BC_W'(C2_BITS - 1);
      default: last_idx = BC_W'(SYM_W - 1);
    endcase
  endfunction

  always_comb begin
    state_nx   = state;
    period_nx  = period;
    cnt_nx     = cnt;
    bit_cnt_nx = bit_cnt;
    ty_hi_nx   = ty_hi;
    ftype_nx   = ftype;
    shreg_nx   = shreg;
    ty_bad     = 1'b0;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    terr_nx    = 1'b0;
    serr_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (!(&sync2)) begin
          state_nx  = START;
          period_nx = clkdiv_eff;
          cnt_nx    = start_load;
        end
      end
      START: begin
        cnt_nx = cnt_step;
        if (tick) begin
          if (bit_now == '0) begin
            state_nx   = TYPE;
            bit_cnt_nx = BC_W'(1);
          end else if (&bit_now) begin
            state_nx = IDLE;
          end else begin
            serr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      TYPE: begin
        cnt_nx = cnt_step;
        if (tick) begin
          if (bit_cnt != '0) begin
            ty_hi_nx   = bit_now;
            bit_cnt_nx = bit_cnt - 1'b1;
          end else begin
            // lane 0 is authoritative; every other lane must agree with it
            ftype_nx = {ty_hi[0], bit_now[0]};
            for (int l = 1; l < LANES; l++) begin
              if ({ty_hi[l], bit_now[l]} != {ty_hi[0], bit_now[0]}) ty_bad = 1'b1;
            end
            if (ty_bad || ftype_nx == 2'b11) begin
              terr_nx  = 1'b1;
              state_nx = WAIT_IDLE;
            end else begin
              state_nx   = PAYLOAD;
              bit_cnt_nx = last_idx(ftype_nx);
              shreg_nx   = '0;
            end
          end
        end
      end
      PAYLOAD: begin
        cnt_nx = cnt_step;
        if (tick) begin
          for (int l = 0; l < LANES; l++) begin
            shreg_nx[l] = {shreg[l][SYM_W-2:0], bit_now[l]};
          end
          if (bit_cnt == '0) state_nx = STOP;
          else               bit_cnt_nx = bit_cnt - 1'b1;
        end
      end
      STOP: begin
        cnt_nx = cnt_step;
        if (tick) begin
          if (&bit_now) begin
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (&sync2) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // comma payloads are packed contiguously, lane 0 in the low bits
  always_comb begin
    data_pk = '0;
    for (int l = 0; l < LANES; l++) begin
      case (ftype)
        2'b01:   data_pk[l*C1_BITS +: C1_BITS] = shreg[l][C1_BITS-1:0];
        2'b10:   data_pk[l*C2_BITS +: C2_BITS] = shreg[l][C2_BITS-1:0];
        default: data_pk[l*SYM_W +: SYM_W]     = shreg[l];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      period       <= '0;
      cnt          <= '0;
      bit_cnt      <= '0;
      ty_hi        <= '0;
      ftype        <= '0;
      shreg        <= '0;
      data_q       <= '0;
      frame_type_q <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      terr_q       <= 1'b0;
      serr_q       <= 1'b0;
    end else begin
      state   <= state_nx;
      period  <= period_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      ty_hi   <= ty_hi_nx;
      ftype   <= ftype_nx;
      shreg   <= shreg_nx;
      valid_q <= valid_nx;
      ferr_q  <= ferr_nx;
      terr_q  <= terr_nx;
      serr_q  <= serr_nx;
      if (valid_nx) begin
        data_q       <= data_pk;
        frame_type_q <= ftype;
      end
    end
  end

  assign bus.data        = data_q;
  assign bus.frame_type  = frame_type_q;
  assign bus.valid       = valid_q;
  assign bus.framing_err = ferr_q;
  assign bus.type_err    = terr_q;
  assign bus.skew_err    = serr_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_lanes.sv
// Directed bench for uart_rx_lanes: data, comma1, comma2 (back-to-back),
// framing, skew and type errors, reset mid-frame and short bit periods.
`timescale 1ns/1ps
module tb_uart_rx_lanes;
  localparam int LANES    = 5;
  localparam int SYM_W    = 10;
  localparam int C1_BITS  = 2;
  localparam int C2_BITS  = 4;
  localparam int CLKDIV_W = 10;
  localparam int DW       = LANES * SYM_W;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_EXTRA = 1;
`else
  localparam int VOTE_EXTRA = 0;
`endif
  localparam logic [DW-1:0] PLAN = {10'b1101010100, 10'b1010101011,
                                    10'b1111000011, 10'b0000111100,
                                    10'b1100110011};
  localparam logic [DW-1:0] PLAN_INV = {10'b0010101011, 10'b0101010100,
                                        10'b0000111100, 10'b1111000011,
                                        10'b0011001100};

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_rx_lanes_if #(.LANES(LANES), .SYM_W(SYM_W), .CLKDIV_W(CLKDIV_W)) bus ();

  uart_rx_lanes #(
    .LANES(LANES), .SYM_W(SYM_W), .C1_BITS(C1_BITS), .C2_BITS(C2_BITS),
    .CLKDIV_W(CLKDIV_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_terr = 0, n_serr = 0, n_multi = 0;
  logic [DW-1:0] v_data [$];
  logic [1:0]    v_type [$];
  int            v_cyc  [$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.valid) begin
      n_valid++;
      v_data.push_back(bus.data);
      v_type.push_back(bus.frame_type);
      v_cyc.push_back(cyc);
    end
    if (bus.framing_err) n_ferr++;
    if (bus.type_err)    n_terr++;
    if (bus.skew_err)    n_serr++;
    if (int'(bus.valid) + int'(bus.framing_err) + int'(bus.type_err) + int'(bus.skew_err) > 1)
      n_multi++;
  end

  // stimulus state
  logic [LANES-1:0]    col [0:63];
  int                  ncol;
  logic [SYM_W-1:0]    pay [LANES];
  logic [1:0]          ty  [LANES];
  int                  dly [LANES];
  int                  rst_at, busy_at, chg_at;
  logic [CLKDIV_W-1:0] chg_val;
  int                  t0;
  int                  sv, sf, st, ss;

  task automatic reset_stim();
    ncol    = 0;
    rst_at  = -1;
    busy_at = -1;
    chg_at  = -1;
    chg_val = '0;
    for (int l = 0; l < LANES; l++) dly[l] = 0;
  endtask

  task automatic set_ty(input logic [1:0] t);
    for (int l = 0; l < LANES; l++) ty[l] = t;
  endtask

  task automatic set_plan(input bit inv);
    logic [DW-1:0] w;
    w = inv ? PLAN_INV : PLAN;
    for (int l = 0; l < LANES; l++) pay[l] = w[l*SYM_W +: SYM_W];
  endtask

  task automatic add_frame(input int n, input int stop_low, input bit trunc);
    col[ncol] = '0;
    for (int l = 0; l < LANES; l++) begin
      col[ncol+1][l] = ty[l][1];
      col[ncol+2][l] = ty[l][0];
    end
    if (trunc) begin
      ncol += 3;
    end else begin
      for (int i = 0; i < n; i++)
        for (int l = 0; l < LANES; l++) col[ncol+3+i][l] = pay[l][n-1-i];
      for (int l = 0; l < LANES; l++) col[ncol+3+n][l] = (l == stop_low) ? 1'b0 : 1'b1;
      ncol += 4 + n;
    end
  endtask

  task automatic drive(input int per);
    int maxd, total, idx;
    logic [LANES-1:0] v;
    maxd = 0;
    for (int l = 0; l < LANES; l++) if (dly[l] > maxd) maxd = dly[l];
    total = maxd + ncol * per + 3 * per + 20;
    t0 = cyc;
    for (int t = 0; t < total; t++) begin
      for (int l = 0; l < LANES; l++) begin
        if (t < dly[l] || (rst_at >= 0 && t >= rst_at)) begin
          v[l] = 1'b1;
        end else begin
          idx  = (t - dly[l]) / per;
          v[l] = (idx < ncol) ? col[idx][l] : 1'b1;
        end
      end
      bus.uart_in = v;
      if (t == chg_at) bus.clkdiv = chg_val;
      if (t == busy_at) check("busy_mid_frame", 64'(bus.busy), 64'd1);
      if (t == rst_at) RST = 1'b1;
      if (rst_at >= 0 && t == rst_at + 1) begin
        check("rst_data", 64'(bus.data), 64'd0);
        check("rst_type", 64'(bus.frame_type), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_pulses", 64'({bus.valid, bus.framing_err, bus.type_err, bus.skew_err}), 64'd0);
        RST = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic snap();
    sv = n_valid;
    sf = n_ferr;
    st = n_terr;
    ss = n_serr;
  endtask

  task automatic check_counts(input string tag, input int ev, input int ef, input int et, input int es);
    check({tag, "_valid_cnt"}, 64'(n_valid - sv), 64'(ev));
    check({tag, "_ferr_cnt"},  64'(n_ferr - sf),  64'(ef));
    check({tag, "_terr_cnt"},  64'(n_terr - st),  64'(et));
    check({tag, "_serr_cnt"},  64'(n_serr - ss),  64'(es));
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [DW-1:0] ed, input logic [1:0] et);
    if (v_data.size() > idx) begin
      check({tag, "_data"}, 64'(v_data[idx]), 64'(ed));
      check({tag, "_type"}, 64'(v_type[idx]), 64'(et));
    end else begin
      check({tag, "_frame_seen"}, 64'(v_data.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    bus.uart_in = '1;
    bus.clkdiv  = CLKDIV_W'(10);
    reset_stim();
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("reset_data", 64'(bus.data), 64'd0);
    check("reset_type", 64'(bus.frame_type), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_pulses", 64'({bus.valid, bus.framing_err, bus.type_err, bus.skew_err}), 64'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // data frame, P=10
    snap(); reset_stim(); set_plan(0); set_ty(2'b00);
    add_frame(SYM_W, -1, 0);
    busy_at = 20;
    drive(10);
    check_counts("data", 1, 0, 0, 0);
    check_frame("data", sv, PLAN, 2'b00);
    if (v_cyc.size() > sv) check("data_latency", 64'(v_cyc[sv] - t0), 64'(138 + VOTE_EXTRA));

    // comma1, clkdiv changed mid-frame must not disturb it
    snap(); reset_stim(); set_ty(2'b01);
    pay[4] = 10'b10; pay[3] = 10'b11; pay[2] = 10'b01; pay[1] = 10'b01; pay[0] = 10'b11;
    add_frame(C1_BITS, -1, 0);
    chg_at = 40; chg_val = CLKDIV_W'(7);
    drive(10);
    bus.clkdiv = CLKDIV_W'(10);
    check_counts("comma1", 1, 0, 0, 0);
    check_frame("comma1", sv, DW'(10'b1011010111), 2'b01);

    // comma2 immediately followed by a data frame
    snap(); reset_stim(); set_ty(2'b10);
    pay[4] = 10'b1000; pay[3] = 10'b1001; pay[2] = 10'b1110; pay[1] = 10'b0011; pay[0] = 10'b0101;
    add_frame(C2_BITS, -1, 0);
    set_plan(0); set_ty(2'b00);
    add_frame(SYM_W, -1, 0);
    drive(10);
    check_counts("b2b", 2, 0, 0, 0);
    check_frame("b2b_comma2", sv, DW'(20'b10001001111000110101), 2'b10);
    check_frame("b2b_data", sv + 1, PLAN, 2'b00);

    // stop bit low on lane 2
    snap(); reset_stim(); set_plan(1); set_ty(2'b00);
    add_frame(SYM_W, 2, 0);
    drive(10);
    check_counts("framing", 0, 1, 0, 0);
    check("framing_data_held", 64'(bus.data), 64'(PLAN));
    snap(); reset_stim(); set_plan(1); set_ty(2'b00);
    add_frame(SYM_W, -1, 0);
    drive(10);
    check_counts("after_framing", 1, 0, 0, 0);
    check_frame("after_framing", sv, PLAN_INV, 2'b00);

    // lane 3 start 8 cycles late
    snap(); reset_stim(); set_ty(2'b00);
    add_frame(0, -1, 1);
    dly[3] = 8;
    drive(10);
    check_counts("skew", 0, 0, 0, 1);

    // lane 1 type 01 vs lane 0 type 00
    snap(); reset_stim(); set_ty(2'b00); ty[1] = 2'b01;
    add_frame(0, -1, 1);
    drive(10);
    check_counts("type_mismatch", 0, 0, 1, 0);

    // reserved type 11
    snap(); reset_stim(); set_ty(2'b11);
    add_frame(0, -1, 1);
    drive(10);
    check_counts("type_11", 0, 0, 1, 0);

    // reset mid-payload
    snap(); reset_stim(); set_plan(0); set_ty(2'b00);
    add_frame(SYM_W, -1, 0);
    rst_at = 50;
    drive(10);
    check_counts("rst_mid", 0, 0, 0, 0);

    // clkdiv = 4
    bus.clkdiv = CLKDIV_W'(4);
    snap(); reset_stim(); set_plan(0); set_ty(2'b00);
    add_frame(SYM_W, -1, 0);
    drive(4);
    check_counts("div4", 1, 0, 0, 0);
    check_frame("div4", sv, PLAN, 2'b00);
    if (v_cyc.size() > sv) check("div4_latency", 64'(v_cyc[sv] - t0), 64'(57 + VOTE_EXTRA));

    // clkdiv = 2, clamped to 4
    bus.clkdiv = CLKDIV_W'(2);
    snap(); reset_stim(); set_plan(1); set_ty(2'b00);
    add_frame(SYM_W, -1, 0);
    drive(4);
    check_counts("div2", 1, 0, 0, 0);
    check_frame("div2", sv, PLAN_INV, 2'b00);

    check("pulse_exclusive", 64'(n_multi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
